// File: rtl/chacha_block_engine.sv
// Iterative ChaCha block function (ChaCha8/12/20), 1 or 4 quarter-rounds per clock.
// Optional CHACHA_CTR_AUTOINC_EN adds `next`/`ctr_wrap` for counter auto-increment.
module chacha_block_engine #(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
`ifdef CHACHA_CTR_AUTOINC_EN
  input  logic         next,
  output logic         ctr_wrap,
`endif
  output logic [511:0] ks,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;
  typedef logic [15:0][31:0] block_t;

  localparam int RC_W = $clog2(ROUNDS);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS - 1);
  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  generate
    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
      $error("chacha_block_engine: ROUNDS must be 8, 12 or 20");
    end
    if (!(QR_PER_CYCLE == 1 || QR_PER_CYCLE == 4)) begin : g_bad_qr
      $error("chacha_block_engine: QR_PER_CYCLE must be 1 or 4");
    end
  endgenerate

  function automatic logic [31:0] rotl(input logic [31:0] v, input int sh);
    return (v << sh) | (v >> (32 - sh));
  endfunction

  function automatic logic [127:0] quarter_round(input logic [31:0] a_i, b_i, c_i, d_i);
    logic [31:0] a, b, c, d;
    a = a_i + b_i;  d = rotl(d_i ^ a, 16);
    c = c_i + d;    b = rotl(b_i ^ c, 12);
    a = a + b;      d = rotl(d ^ a, 8);
    c = c + d;      b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  state_e            state_q, state_d;
  block_t            init_q, work_q, work_d, load_blk, ks_q, ks_d;
  logic [RC_W-1:0]   rc_q;
  logic [1:0]        qc_q;
  logic              start, round_done, last_round;

  // Diagonal rounds shift column k's row r by r positions (mod 4).
  always_comb begin
    logic [3:0]   i0, i1, i2, i3;
    logic [127:0] qr_out;
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    work_d = work_q;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0; qr_out = '0;
    for (int k = 0; k < 4; k++) begin
      if (QR_PER_CYCLE == 4 || qc_q == 2'(k)) begin
        i0 = {2'd0, 2'(k)};
        i1 = {2'd1, rc_q[0] ? 2'(k + 1) : 2'(k)};
        i2 = {2'd2, rc_q[0] ? 2'(k + 2) : 2'(k)};
        i3 = {2'd3, rc_q[0] ? 2'(k + 3) : 2'(k)};
        qr_out = quarter_round(work_q[i0], work_q[i1], work_q[i2], work_q[i3]);
        work_d[i0] = qr_out[31:0];
        work_d[i1] = qr_out[63:32];
        work_d[i2] = qr_out[95:64];
        work_d[i3] = qr_out[127:96];
      end
    end
  end

  always_comb begin
    load_blk[3:0] = SIGMA;
    for (int i = 0; i < 8; i++) load_blk[4+i] = key[32*i +: 32];
    load_blk[12] = counter;
    for (int j = 0; j < 3; j++) load_blk[13+j] = nonce[32*j +: 32];
`ifdef CHACHA_CTR_AUTOINC_EN
    if (!in_valid) begin
      load_blk     = init_q;
      load_blk[12] = init_q[12] + 32'd1;
    end
`endif
    for (int i = 0; i < 16; i++) ks_d[i] = work_q[i] + init_q[i];
  end

`ifdef CHACHA_CTR_AUTOINC_EN
  logic primed_q, wrap_q;
  assign start    = in_ready && (in_valid || (next && primed_q));
  assign ctr_wrap = wrap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (start) begin
      primed_q <= 1'b1;
      wrap_q   <= in_valid ? 1'b0 : (wrap_q | (init_q[12] == 32'hFFFF_FFFF));
    end
  end
`else
  assign start = in_ready && in_valid;
`endif

  assign round_done = (QR_PER_CYCLE == 4) || (qc_q == 2'd3);
  assign last_round = (state_q == S_ROUND) && round_done && (rc_q == RC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)      state_d = S_ROUND;
      S_ROUND: if (last_round) state_d = S_FINAL;
      S_FINAL:                 state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the 16-word state arrays are flops, not RAM, so clearing them on reset is cheap and required.
      init_q <= '0;
      work_q <= '0;
      ks_q   <= '0;
      rc_q   <= '0;
      qc_q   <= '0;
    end else begin
      if (start) begin
        init_q <= load_blk;
        work_q <= load_blk;
        rc_q   <= '0;
        qc_q   <= '0;
      end else if (state_q == S_ROUND) begin
        work_q <= work_d;
        if (round_done) rc_q <= rc_q + 1'b1;
        if (QR_PER_CYCLE == 1) qc_q <= qc_q + 2'd1;
      end
      if (state_q == S_FINAL) ks_q <= ks_d;
    end
  end

  assign ks = ks_q;

endmodule

// File: tb/tb_chacha_block_engine.sv
// Directed bench for chacha_block_engine: RFC 8439 vectors, latency, backpressure,
// mid-round reset, ChaCha8/12 and 1-QR variants, and the counter auto-increment option.
module tb_chacha_block_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  counter = '0;
  logic         iv   [4];
  logic         ordy [4];
  logic         ir   [4];
  logic         ov   [4];
  logic [511:0] ks   [4];
`ifdef CHACHA_CTR_AUTOINC_EN
  logic         nxt = 1'b0;
  logic         wrap [4];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chacha_block_engine #(.ROUNDS(20), .QR_PER_CYCLE(4)) u_c20q4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .key(key), .nonce(nonce), .counter(counter),
`ifdef CHACHA_CTR_AUTOINC_EN
    .next(nxt), .ctr_wrap(wrap[0]),
`endif
    .ks(ks[0]), .out_valid(ov[0]), .out_ready(ordy[0]));

  chacha_block_engine #(.ROUNDS(20), .QR_PER_CYCLE(1)) u_c20q1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .key(key), .nonce(nonce), .counter(counter),
`ifdef CHACHA_CTR_AUTOINC_EN
    .next(1'b0), .ctr_wrap(wrap[1]),
`endif
    .ks(ks[1]), .out_valid(ov[1]), .out_ready(ordy[1]));

  chacha_block_engine #(.ROUNDS(8), .QR_PER_CYCLE(4)) u_c8q4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .key(key), .nonce(nonce), .counter(counter),
`ifdef CHACHA_CTR_AUTOINC_EN
    .next(1'b0), .ctr_wrap(wrap[2]),
`endif
    .ks(ks[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  chacha_block_engine #(.ROUNDS(12), .QR_PER_CYCLE(1)) u_c12q1 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
    .key(key), .nonce(nonce), .counter(counter),
`ifdef CHACHA_CTR_AUTOINC_EN
    .next(1'b0), .ctr_wrap(wrap[3]),
`endif
    .ks(ks[3]), .out_valid(ov[3]), .out_ready(ordy[3]));

  // Quarter-round operand order as listed in RFC 8439: four columns, then four diagonals.
  localparam int QA [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int QB [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
  localparam int QC [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
  localparam int QD [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

  function automatic logic [31:0] rol(input logic [31:0] v, input int sh);
    return (v << sh) | (v >> (32 - sh));
  endfunction

  function automatic logic [511:0] ref_block(input int rounds, input logic [255:0] k,
                                             input logic [95:0] nn, input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [31:0]  a, b, cc, d;
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13+j] = nn[32*j +: 32];
    x = s;
    for (int dr = 0; dr < rounds / 2; dr++) begin
      for (int q = 0; q < 8; q++) begin
        a = x[QA[q]]; b = x[QB[q]]; cc = x[QC[q]]; d = x[QD[q]];
        a += b; d ^= a; d = rol(d, 16);
        cc += d; b ^= cc; b = rol(b, 12);
        a += b; d ^= a; d = rol(d, 8);
        cc += d; b ^= cc; b = rol(b, 7);
        x[QA[q]] = a; x[QB[q]] = b; x[QC[q]] = cc; x[QD[q]] = d;
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_block(input int idx, input logic [255:0] k, input logic [95:0] nn,
                             input logic [31:0] c);
    @(negedge clk);
    key = k; nonce = nn; counter = c; iv[idx] = 1'b1;
    check("accept_ready", ir[idx], 1'b1);
    @(posedge clk); #1;
    iv[idx] = 1'b0;
  endtask

  task automatic wait_block(input int idx, output int n);
    n = 0;
    while (!ov[idx] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake(input int idx);
    @(negedge clk);
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    ordy[idx] = 1'b0;
    check("hs_out_valid", ov[idx], 1'b0);
    check("hs_in_ready", ir[idx], 1'b1);
  endtask

  task automatic run_ref(input int idx, input int rounds, input int lat, input string tag,
                         input logic [255:0] k, input logic [95:0] nn, input logic [31:0] c);
    int n;
    start_block(idx, k, nn, c);
    wait_block(idx, n);
    check({tag, "_latency"}, 512'(n), 512'(lat));
    check({tag, "_block"}, ks[idx], ref_block(rounds, k, nn, c));
    handshake(idx);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;
    logic [511:0] hold;
    int n;

    for (int i = 0; i < 4; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
    for (int b = 0; b < 32; b++) rfc_key[8*b +: 8] = 8'(b);
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    #1;
    check("rst_in_ready", ir[0], 1'b1);
    check("rst_out_valid", ov[0], 1'b0);
    check("rst_ks", ks[0], '0);
`ifdef CHACHA_CTR_AUTOINC_EN
    check("rst_ctr_wrap", wrap[0], 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef CHACHA_CTR_AUTOINC_EN
    @(negedge clk); nxt = 1'b1;
    @(posedge clk); #1; nxt = 1'b0;
    check("next_before_load_ignored", ir[0], 1'b1);
`endif

    // RFC 8439 block-function vector on the ChaCha20, 4-QR engine.
    start_block(0, rfc_key, rfc_nonce, 32'd1);
    wait_block(0, n);
    check("rfc_latency", 512'(n), 512'd21);
    check("rfc_w0", ks[0][31:0],   32'he4e7f110);
    check("rfc_w1", ks[0][63:32],  32'h15593bd1);
    check("rfc_w2", ks[0][95:64],  32'h1fdd0f50);
    check("rfc_w3", ks[0][127:96], 32'hc47120a3);
    check("rfc_block", ks[0], ref_block(20, rfc_key, rfc_nonce, 32'd1));

    // Hold out_ready low; in_valid pulses with different inputs must be ignored.
    hold = ks[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv[0] = ~iv[0];
      key = ~rfc_key;
      counter = 32'(i + 100);
      @(posedge clk); #1;
      check("bp_ks_stable", ks[0], hold);
      check("bp_out_valid", ov[0], 1'b1);
      check("bp_in_ready", ir[0], 1'b0);
    end
    @(negedge clk); iv[0] = 1'b1;
    handshake(0);
    iv[0] = 1'b0;
    @(posedge clk); #1;
    check("post_hs_not_started", ir[0], 1'b1);
    check("post_hs_no_valid", ov[0], 1'b0);

    // All-zero vector; inputs changed right after acceptance must not matter.
    start_block(0, '0, '0, 32'd0);
    key = '1; nonce = '1; counter = 32'h12345678;
    wait_block(0, n);
    check("zero_latency", 512'(n), 512'd21);
    check("zero_w0", ks[0][31:0],  32'hade0b876);
    check("zero_w1", ks[0][63:32], 32'h903df1a0);
    check("zero_block", ks[0], ref_block(20, '0, '0, 32'd0));
    handshake(0);

    run_ref(0, 20, 21, "ctr_max", rfc_key, rfc_nonce, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of the round phase.
    start_block(0, rfc_key, rfc_nonce, 32'd1);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", ov[0], 1'b0);
    check("midrst_ks", ks[0], '0);
    check("midrst_in_ready", ir[0], 1'b1);
    @(negedge clk); rst = 1'b0;
    start_block(0, rfc_key, rfc_nonce, 32'd1);
    wait_block(0, n);
    check("after_rst_latency", 512'(n), 512'd21);
    check("after_rst_w0", ks[0][31:0], 32'he4e7f110);
    check("after_rst_block", ks[0], ref_block(20, rfc_key, rfc_nonce, 32'd1));
    handshake(0);

`ifdef CHACHA_CTR_AUTOINC_EN
    run_ref(0, 20, 21, "auto_base", rfc_key, rfc_nonce, 32'hFFFF_FFFF);
    check("auto_base_wrap", wrap[0], 1'b0);
    @(negedge clk); nxt = 1'b1; key = '0; counter = 32'd77;
    @(posedge clk); #1; nxt = 1'b0;
    check("auto_started", ir[0], 1'b0);
    wait_block(0, n);
    check("auto_latency", 512'(n), 512'd21);
    check("auto_block", ks[0], ref_block(20, rfc_key, rfc_nonce, 32'd0));
    check("auto_wrap_set", wrap[0], 1'b1);
    handshake(0);
    check("auto_wrap_sticky", wrap[0], 1'b1);
    // in_valid and next together: fresh inputs win and ctr_wrap clears.
    @(negedge clk);
    key = rfc_key; nonce = rfc_nonce; counter = 32'd5; iv[0] = 1'b1; nxt = 1'b1;
    @(posedge clk); #1; iv[0] = 1'b0; nxt = 1'b0;
    check("reload_wrap_clear", wrap[0], 1'b0);
    wait_block(0, n);
    check("reload_block", ks[0], ref_block(20, rfc_key, rfc_nonce, 32'd5));
    handshake(0);
`endif

    // Other configurations: one QR per cycle, ChaCha8 and ChaCha12.
    start_block(1, rfc_key, rfc_nonce, 32'd1);
    wait_block(1, n);
    check("q1_latency", 512'(n), 512'd81);
    check("q1_w0", ks[1][31:0], 32'he4e7f110);
    check("q1_block", ks[1], ref_block(20, rfc_key, rfc_nonce, 32'd1));
    handshake(1);
    run_ref(2, 8, 9, "c8_zero", '0, '0, 32'd0);
    run_ref(2, 8, 9, "c8_rfc", rfc_key, rfc_nonce, 32'd1);
    run_ref(3, 12, 49, "c12_zero", '0, '0, 32'd0);
    run_ref(3, 12, 49, "c12_rfc", rfc_key, rfc_nonce, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chacha_block_engine.md
Name: chacha_block_engine

Overview:
Iterative, parametrised ChaCha block function. It produces one 512-bit keystream block from a 256-bit key, 96-bit nonce and 32-bit block counter.
- Successor to the single combinational quarter-round unit. Round count and quarter-rounds per cycle are configurable, so one core covers ChaCha8/12/20 and area-vs-latency trade-offs.
- Sits between the cipher control layer and the keystream XOR datapath.
- Uses valid/ready handshakes on both input and output.

Parameters:
- ROUNDS, 20, total rounds; legal values 8, 12, 20 (must be even). Each round is one column or one diagonal half of a double round.
- QR_PER_CYCLE, 4, quarter-rounds evaluated per clock; legal values 1 or 4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request carries a valid key/nonce/counter.
- in_ready  output  1  engine can accept a request.
- key  input  256  key word i = key[32i+31:32i]; loaded into state word 4+i.
- nonce  input  96  nonce word j = nonce[32j+31:32j]; loaded into state word 13+j.
- counter  input  32  block counter; loaded into state word 12.
- ks  output  512  keystream; word i = ks[32i+31:32i].
- out_valid  output  1  ks holds a complete block.
- out_ready  input  1  consumer accepts ks.

Behaviour:
- Reset (asynchronous, any state): state := IDLE; in_ready=1, out_valid=0, ks=0; working and initial state registers cleared.
- State words 0..3 are constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
- All arithmetic is mod 2^32. Quarter-round is the standard sequence: add, xor, rotate-left by 16, 12, 8, 7.
- FSM states:
  - IDLE: in_ready=1. On in_valid: load the initial and working state (16x32), clear round counter rc and sub-counter qc, go to ROUND.
  - ROUND: in_ready=0.
    - Even rc applies column QRs (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
    - Odd rc applies diagonal QRs (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
    - QR_PER_CYCLE=4: all four QRs in one cycle; rc++ each cycle.
    - QR_PER_CYCLE=1: QR number qc (0..3) per cycle; rc++ when qc wraps 3->0.
    - After round ROUNDS-1 completes, go to FINAL.
  - FINAL: ks word i := working[i] + initial[i]; out_valid := 1; go to DONE. One cycle.
  - DONE: out_valid=1, ks held stable. When out_valid && out_ready: out_valid := 0, go to IDLE. No new request is accepted in the same cycle.
- Latency, from the accepting edge to out_valid high:
  - ROUNDS+1 cycles when QR_PER_CYCLE=4 (21 for ChaCha20).
  - 4*ROUNDS+1 cycles when QR_PER_CYCLE=1 (81).
- Inputs are sampled only at the accepting edge; changes afterwards have no effect.
- in_valid while busy: ignored, not queued (in_ready=0).
- out_ready held low: ks and out_valid hold indefinitely.
- Counter value 0xFFFFFFFF is used as given; no carry into the nonce.
- Illegal ROUNDS or QR_PER_CYCLE: elaboration-time error.

Optional Feature:
CHACHA_CTR_AUTOINC_EN
- Defined:
  - Adds input `next` (1 bit) and output `ctr_wrap` (1 bit, reset 0).
  - In IDLE, after at least one block, `next` with in_valid low starts a new block. It reuses the stored key and nonce with stored counter+1; latency is identical.
  - Counter 0xFFFFFFFF+1 wraps to 0 and sets sticky `ctr_wrap`.
  - in_valid clears `ctr_wrap` and reloads all inputs.
  - in_valid has priority over `next` in the same cycle.
  - `next` before any in_valid since reset is ignored.
- Undefined: no `next` or `ctr_wrap` ports; every block requires in_valid with a full key, nonce and counter.

Test Plan:
- RFC 8439 §2.3.2 vector: key bytes 00..1f (word4=0x03020100), nonce words 0x09000000, 0x4a000000, 0x00000000, counter=1, ROUNDS=20 -> ks words 0..3 = 0xe4e7f110, 0x15593bd1, 0x1fdd0f50, 0xc47120a3; out_valid exactly 21 cycles after accept (81 with QR_PER_CYCLE=1).
- All-zero key/nonce, counter 0 -> ks word0 = 0xade0b876, word1 = 0x903df1a0; ROUNDS=8 and 12 outputs match the reference model.
- Backpressure: out_ready low for 10 cycles after out_valid -> ks stable, in_ready=0, in_valid pulses ignored; out_ready high -> one handshake, then IDLE with in_ready=1.
- Assert rst at ROUND cycle 7 -> out_valid=0, ks=0, in_ready=1 immediately. Next request yields the correct vector with normal latency.
- CHACHA_CTR_AUTOINC_EN: load counter 0xFFFFFFFF, then pulse `next` -> second block equals the fresh-load result with counter 0, and ctr_wrap=1. A new in_valid clears ctr_wrap.
